// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers.
// Optional AXIL_REG_PROT_CHECK_EN: non-secure access to reg 0 gets SLVERR.
module axi_lite_reg_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] RESET_VAL  = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int IDXW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRBW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    assign reg_q = regs;

    logic [IDXW-1:0] aw_idx, ar_idx;
    logic            aw_err, ar_err;
    logic            aw_prot_err, ar_prot_err;
    logic            unused_prot;

    assign aw_idx = awaddr[2 +: IDXW];
    assign ar_idx = araddr[2 +: IDXW];
    assign unused_prot = ^{awprot, arprot};

`ifdef AXIL_REG_PROT_CHECK_EN
    assign aw_prot_err = awprot[1] && (aw_idx == '0);
    assign ar_prot_err = arprot[1] && (ar_idx == '0);
`else
    assign aw_prot_err = 1'b0;
    assign ar_prot_err = 1'b0;
`endif

    assign aw_err = (awaddr >= LIMIT) || aw_prot_err;
    assign ar_err = (araddr >= LIMIT) || ar_prot_err;

    // write path
    wstate_t            wstate, wstate_d;
    logic               aw_got, aw_got_d, w_got, w_got_d;
    logic               aw_hs, w_hs, commit;
    logic [IDXW-1:0]    aw_idx_q, c_idx;
    logic               aw_err_q, c_err;
    logic [DATA_WIDTH-1:0] wdata_q, c_data;
    logic [STRBW-1:0]   wstrb_q, c_strb;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // either channel may arrive on the commit edge itself
    assign c_idx  = aw_got ? aw_idx_q : aw_idx;
    assign c_err  = aw_got ? aw_err_q : aw_err;
    assign c_data = w_got ? wdata_q : wdata;
    assign c_strb = w_got ? wstrb_q : wstrb;

    always_comb begin
        wstate_d = wstate;
        aw_got_d = aw_got;
        w_got_d  = w_got;
        commit   = 1'b0;
        unique case (wstate)
            W_COLLECT: begin
                if (aw_hs) aw_got_d = 1'b1;
                if (w_hs)  w_got_d  = 1'b1;
                if (aw_got_d && w_got_d) begin
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    wstate_d = W_COLLECT;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate       <= W_COLLECT;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bresp        <= OKAY;
            aw_idx_q     <= '0;
            aw_err_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            reg_wr_pulse <= '0;
            regs         <= {NUM_REGS{RESET_VAL}};
        end else begin
            wstate       <= wstate_d;
            aw_got       <= aw_got_d;
            w_got        <= w_got_d;
            awready      <= (wstate_d == W_COLLECT) && !aw_got_d;
            wready       <= (wstate_d == W_COLLECT) && !w_got_d;
            reg_wr_pulse <= '0;
            if (aw_hs) begin
                aw_idx_q <= aw_idx;
                aw_err_q <= aw_err;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= c_err ? SLVERR : OKAY;
                if (!c_err) begin
                    reg_wr_pulse[c_idx] <= 1'b1;
                    for (int b = 0; b < STRBW; b++) begin
                        if (c_strb[b])
                            regs[c_idx][8*b +: 8] <= c_data[8*b +: 8];
                    end
                end
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // read path
    rstate_t rstate, rstate_d;
    logic    ar_hs;

    assign ar_hs = arvalid && arready;

    always_comb begin
        rstate_d = rstate;
        unique case (rstate)
            R_IDLE: if (ar_hs) rstate_d = R_RESP;
            R_RESP: if (rvalid && rready) rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else begin
            rstate  <= rstate_d;
            arready <= (rstate_d == R_IDLE);
            rvalid  <= (rstate_d == R_RESP);
            if (ar_hs) begin
                rdata <= ar_err ? '0 : regs[ar_idx];
                rresp <= ar_err ? SLVERR : OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized bench for axi_lite_reg_slave against an array-based register model.
// Honors AXIL_REG_PROT_CHECK_EN when the design is built with it.
module tb_axi_lite_reg_slave;

    localparam int NR = 16;
`ifdef AXIL_REG_PROT_CHECK_EN
    localparam bit PROT_CHK = 1'b1;
`else
    localparam bit PROT_CHK = 1'b0;
`endif

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [31:0]      awaddr, wdata, araddr, rdata;
    logic [2:0]       awprot, arprot;
    logic [3:0]       wstrb;
    logic             awvalid, awready, wvalid, wready;
    logic             bvalid, bready, arvalid, arready;
    logic             rvalid, rready;
    logic [1:0]       bresp, rresp;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0]    reg_wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mem [NR];

    always #5 aclk = ~aclk;

    axi_lite_reg_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .RESET_VAL(32'h0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] addr, input logic [2:0] prot);
        if (addr >= NR * 4) return 1'b1;
        return PROT_CHK && prot[1] && (addr / 4 == 0);
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr,
                                                input logic [2:0] prot);
        return model_err(addr, prot) ? 32'h0 : mem[addr / 4];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem[i] = 32'h0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) chk(tag, reg_q[i*32 +: 32], mem[i]);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w, err;
        int cyc = 0;
        logic [NR-1:0] exp_pulse = '0;
        err = model_err(addr, prot);
        while (!(aw_done && w_done) && cyc < 60) begin
            @(negedge aclk);
            awaddr  = addr;
            awprot  = prot;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            if (w_done && !aw_done) chk("wready_low_held", wready, 0);
            if (aw_done && !w_done) chk("awready_low_held", awready, 0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge aclk);
            aw_done |= hs_aw;
            w_done  |= hs_w;
            cyc++;
        end
        if (!(aw_done && w_done)) chk("write_hs_timeout", 0, 1);
        @(negedge aclk);
        awvalid = 0;
        wvalid  = 0;
        if (!err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[addr / 4][8*b +: 8] = data[8*b +: 8];
            exp_pulse[addr / 4] = 1'b1;
        end
        chk("bvalid_lat", bvalid, 1);
        chk("bresp", bresp, err ? 2'b10 : 2'b00);
        chk("wr_pulse", reg_wr_pulse, exp_pulse);
        check_regs("reg_q_after_wr");
        for (int k = 0; k < b_dly; k++) begin
            @(negedge aclk);
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, err ? 2'b10 : 2'b00);
            chk("awready_bwait", awready, 0);
            chk("wready_bwait", wready, 0);
            chk("pulse_once", reg_wr_pulse, 0);
        end
        bready = 1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 0;
        chk("bvalid_clr", bvalid, 0);
        chk("awready_back", awready, 1);
        chk("wready_back", wready, 1);
        chk("pulse_clr", reg_wr_pulse, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot,
                            input int ar_dly, input int r_dly,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit done = 0, hs;
        int cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge aclk);
            araddr  = addr;
            arprot  = prot;
            arvalid = cyc >= ar_dly;
            hs = arvalid && arready;
            @(posedge aclk);
            done = hs;
            cyc++;
        end
        if (!done) chk("read_hs_timeout", 0, 1);
        @(negedge aclk);
        arvalid = 0;
        chk("rvalid_lat", rvalid, 1);
        chk("rdata", rdata, exp_data);
        chk("rresp", rresp, exp_resp);
        for (int k = 0; k < r_dly; k++) begin
            @(negedge aclk);
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, exp_data);
            chk("arready_rwait", arready, 0);
        end
        rready = 1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 0;
        chk("rvalid_clr", rvalid, 0);
        chk("arready_back", arready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, pre;
        logic [2:0]  p;
        int op;
        aresetn = 0;
        {awaddr, wdata, araddr, awprot, arprot, wstrb} = '0;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        model_reset();
        repeat (3) @(negedge aclk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulse", reg_wr_pulse, 0);
        check_regs("rst_regs");
        aresetn = 1;
        @(negedge aclk);
        chk("rel_readies", {awready, wready, arready}, 3'b111);

        axi_read(32'h8, 3'b0, 0, 0, 32'h0, 2'b00);
        axi_write(32'h4, 32'hDEADBEEF, 4'b0101, 3'b0, 0, 0, 0);
        chk("reg1_merge", reg_q[32 +: 32], 32'h00AD00EF);
        axi_write(32'h1C, 32'hCAFEF00D, 4'b1111, 3'b0, 3, 0, 5);
        axi_write(32'h40, 32'h11111111, 4'b1111, 3'b0, 0, 0, 0);
        axi_read(32'h40, 3'b0, 0, 0, 32'h0, 2'b10);
        axi_write(32'h8, 32'hA5, 4'b1111, 3'b0, 0, 0, 0);
        fork
            axi_write(32'h8, 32'h12345678, 4'b1111, 3'b0, 0, 0, 0);
            axi_read(32'h8, 3'b0, 0, 0, 32'hA5, 2'b00);
        join
        axi_read(32'h8, 3'b0, 1, 2, 32'h12345678, 2'b00);
        axi_write(32'h32, 32'h0BADCAFE, 4'b0000, 3'b0, 1, 2, 0);

        // reset while a write response is pending
        @(negedge aclk);
        awaddr = 32'hC; awprot = 0; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 0; wvalid = 0;
        chk("pre_rst_bvalid", bvalid, 1);
        aresetn = 0;
        model_reset();
        #1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_readies", {awready, wready, arready}, 0);
        check_regs("mid_rst_regs");
        @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        chk("rel2_readies", {awready, wready, arready}, 3'b111);

        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 2);
            a  = $urandom_range(0, 79);
            d  = $urandom;
            p  = 3'($urandom_range(0, 7));
            if (op == 0) begin
                axi_write(a, d, 4'($urandom_range(0, 15)), p,
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3));
            end else if (op == 1) begin
                axi_read(a, p, $urandom_range(0, 3), $urandom_range(0, 3),
                         model_rdata(a, p), model_err(a, p) ? 2'b10 : 2'b00);
            end else begin
                pre = model_rdata(a, p);
                fork
                    axi_write(a, d, 4'($urandom_range(0, 15)), p, 0, 0,
                              $urandom_range(0, 2));
                    axi_read(a, p, 0, $urandom_range(0, 2), pre,
                             model_err(a, p) ? 2'b10 : 2'b00);
                join
            end
        end
        check_regs("final_regs");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
